mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 46 ++++
 rtl/mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller, the MEM stage and the fetch unit.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] BUSY_IDLE = 2'b00;
    localparam logic [1:0] BUSY_IF   = 2'b01;
    localparam logic [1:0] BUSY_RD   = 2'b10;
    localparam logic [1:0] BUSY_WR   = 2'b11;

    localparam logic [2:0] RLEN_1 = 3'b001;
    localparam logic [2:0] RLEN_2 = 3'b010;
    localparam logic [2:0] RLEN_4 = 3'b100;
    localparam logic [2:0] WLEN_1 = 3'b000;
    localparam logic [2:0] WLEN_2 = 3'b001;
    localparam logic [2:0] WLEN_4 = 3'b011;

    localparam logic [2:0] IF_BYTES = 3'd4;

    // Byte count of a load; codes outside the table fall back to a word.
    function automatic logic [2:0] read_bytes(input logic [2:0] len);
        case (len)
            RLEN_1:  return 3'd1;
            RLEN_2:  return 3'd2;
            RLEN_4:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    // Byte count of a store; codes outside the table fall back to a word.
    function automatic logic [2:0] write_bytes(input logic [2:0] len);
        case (len)
            WLEN_1:  return 3'd1;
            WLEN_2:  return 3'd2;
            WLEN_4:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and MEM-stage loads/stores onto a
// byte-wide synchronous RAM, one byte per cycle, little-endian.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting; MEM write > MEM read > IF fetch at each edge
//   ST_IF_RD  | fetching 4 bytes; a MEM request or dropped if_req aborts it
//   ST_MEM_RD | load of 1/2/4 bytes; not interruptible by requests
//   ST_MEM_WR | store of 1/2/4 bytes; not interruptible by requests
//   ST_DONE   | one-cycle done pulse with the assembled data
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    input  logic        mem_read_req_in,
    input  logic        mem_write_req_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_val_in,
    input  logic [2:0]  mem_len_in,
    output logic        mem_done_out,
    output logic [31:0] mem_val_read_out,
    output logic [1:0]  busy_out,
    output logic [31:0] ram_addr_out,
    output logic        ram_wr_out,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] base_addr;
    logic [31:0] wr_val;
    logic [31:0] rd_data;
    logic [1:0]  op;
    logic        accept_if;
    logic        accept_rd;
    logic        accept_wr;
    logic [31:0] byte_addr;
    logic [7:0]  wr_byte;

    assign byte_addr = base_addr + {29'd0, cnt};
    assign wr_byte   = wr_val[{cnt[1:0], 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request arbitration and all outputs (zero unless addressing
    // a byte or in the done cycle, so reset clears them immediately).
    always_comb begin
        state_nxt        = state;
        accept_if        = 1'b0;
        accept_rd        = 1'b0;
        accept_wr        = 1'b0;
        busy_out         = BUSY_IDLE;
        ram_addr_out     = '0;
        ram_wr_out       = 1'b0;
        ram_data_out     = '0;
        if_done_out      = 1'b0;
        if_inst_out      = '0;
        mem_done_out     = 1'b0;
        mem_val_read_out = '0;
        case (state)
            ST_IDLE: begin
                if (mem_write_req_in) begin
                    accept_wr = 1'b1;
                    state_nxt = ST_MEM_WR;
                end else if (mem_read_req_in) begin
                    accept_rd = 1'b1;
                    state_nxt = ST_MEM_RD;
                end else if (if_req_in) begin
                    accept_if = 1'b1;
                    state_nxt = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                busy_out = BUSY_IF;
                if (cnt < nbytes) begin
                    ram_addr_out = byte_addr;
                end
                // A MEM request takes the RAM over directly; the partial
                // fetch is simply dropped.
                if (mem_write_req_in) begin
                    accept_wr = 1'b1;
                    state_nxt = ST_MEM_WR;
                end else if (mem_read_req_in) begin
                    accept_rd = 1'b1;
                    state_nxt = ST_MEM_RD;
                end else if (!if_req_in) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == nbytes) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_MEM_RD: begin
                busy_out = BUSY_RD;
                if (cnt < nbytes) begin
                    ram_addr_out = byte_addr;
                end
                if (cnt == nbytes) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_MEM_WR: begin
                busy_out     = BUSY_WR;
                ram_addr_out = byte_addr;
                ram_wr_out   = 1'b1;
                ram_data_out = wr_byte;
                if (cnt == nbytes - 3'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (op == BUSY_IF) begin
                    if_done_out = 1'b1;
                    if_inst_out = rd_data;
                end else begin
                    mem_done_out     = 1'b1;
                    mem_val_read_out = rd_data;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Access latches, byte counter and read assembly. Reads run the counter
    // one past the last byte because RAM data lags its address by a cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt       <= '0;
            nbytes    <= '0;
            base_addr <= '0;
            wr_val    <= '0;
            rd_data   <= '0;
            op        <= BUSY_IDLE;
        end else if (accept_if || accept_rd || accept_wr) begin
            cnt       <= '0;
            rd_data   <= '0;
            base_addr <= accept_if ? if_addr_in : mem_addr_in;
            wr_val    <= accept_wr ? mem_val_in : '0;
            if (accept_if) begin
                nbytes <= IF_BYTES;
                op     <= BUSY_IF;
            end else if (accept_wr) begin
                nbytes <= write_bytes(mem_len_in);
                op     <= BUSY_WR;
            end else begin
                nbytes <= read_bytes(mem_len_in);
                op     <= BUSY_RD;
            end
        end else begin
            case (state)
                ST_IF_RD, ST_MEM_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0) begin
                        rd_data[{2'(cnt - 3'd1), 3'b000} +: 8] <= ram_data_in;
                    end
                end
                ST_MEM_WR: begin
                    cnt <= cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, table of directed accesses,
// hand-written abort/priority/reset sequences and random traffic checked
// against a byte-array model of memory.
module tb_mem_ctrl;

    localparam int K_IF = 0;
    localparam int K_RD = 1;
    localparam int K_WR = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] val;
        int          n;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_inst_out;
    logic        mem_read_req_in;
    logic        mem_write_req_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_val_in;
    logic [2:0]  mem_len_in;
    logic        mem_done_out;
    logic [31:0] mem_val_read_out;
    logic [1:0]  busy_out;
    logic [31:0] ram_addr_out;
    logic        ram_wr_out;
    logic [7:0]  ram_data_out;
    logic [7:0]  ram_data_in;

    logic [7:0]  ram [0:65535];
    logic [7:0]  model_mem [0:65535];
    bit          ram_ready = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs [16];

    mem_ctrl dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .if_req_in        (if_req_in),
        .if_addr_in       (if_addr_in),
        .if_done_out      (if_done_out),
        .if_inst_out      (if_inst_out),
        .mem_read_req_in  (mem_read_req_in),
        .mem_write_req_in (mem_write_req_in),
        .mem_addr_in      (mem_addr_in),
        .mem_val_in       (mem_val_in),
        .mem_len_in       (mem_len_in),
        .mem_done_out     (mem_done_out),
        .mem_val_read_out (mem_val_read_out),
        .busy_out         (busy_out),
        .ram_addr_out     (ram_addr_out),
        .ram_wr_out       (ram_wr_out),
        .ram_data_out     (ram_data_out),
        .ram_data_in      (ram_data_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 8);
    endfunction

    // Synchronous byte RAM, 64 KiB aliased over the 32-bit address space.
    always @(posedge clk_in) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
            ram[16'h0007] <= 8'h80;
            ram[16'h0010] <= 8'h34;
            ram[16'h0011] <= 8'h12;
            ram[16'h1000] <= 8'h13;
            ram[16'h1001] <= 8'h05;
            ram[16'h1002] <= 8'h00;
            ram[16'h1003] <= 8'h00;
            ram_ready     <= 1'b1;
        end else begin
            if (ram_wr_out) ram[ram_addr_out[15:0]] <= ram_data_out;
            ram_data_in <= ram[ram_addr_out[15:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_len(input int kind, input logic [2:0] len);
        if (kind == K_IF) return 4;
        if (kind == K_RD) begin
            case (len)
                3'b001:  return 1;
                3'b010:  return 2;
                default: return 4;
            endcase
        end
        case (len)
            3'b000:  return 1;
            3'b001:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = model_mem[16'(addr + 32'(k))];
        return w;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, 32'(busy_out), 32'd0);
        chk({tag, " if_done"}, 32'(if_done_out), 32'd0);
        chk({tag, " mem_done"}, 32'(mem_done_out), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_quiet(tag);
        chk({tag, " ram_addr"}, ram_addr_out, 32'd0);
        chk({tag, " ram_wr"}, 32'(ram_wr_out), 32'd0);
        chk({tag, " ram_data"}, 32'(ram_data_out), 32'd0);
        chk({tag, " if_inst"}, if_inst_out, 32'd0);
        chk({tag, " mem_val"}, mem_val_read_out, 32'd0);
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the
    // idle cycle following the done pulse.
    task automatic run_access(input int kind, input logic [31:0] addr, input logic [2:0] len,
                              input logic [31:0] val, input int n, input logic [31:0] exp_rd);
        int          done_cyc;
        logic [1:0]  exp_busy;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic [7:0]  exp_byte;
        done_cyc = (kind == K_WR) ? n + 1 : n + 2;
        exp_busy = (kind == K_IF) ? 2'b01 : (kind == K_RD) ? 2'b10 : 2'b11;
        if (kind == K_IF) begin
            if_req_in  = 1'b1;
            if_addr_in = addr;
        end else begin
            mem_addr_in = addr;
            mem_len_in  = len;
            mem_val_in  = val;
            if (kind == K_RD) mem_read_req_in = 1'b1;
            else              mem_write_req_in = 1'b1;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        mem_read_req_in  = 1'b0;
        mem_write_req_in = 1'b0;
        for (int c = 1; c <= done_cyc; c++) begin
            if (c > 1) @(negedge clk_in);
            if (c <= n) begin
                exp_addr = addr + 32'(c - 1);
                exp_wr   = (kind == K_WR);
                exp_byte = exp_wr ? 8'(val >> (8 * (c - 1))) : 8'h00;
            end else begin
                exp_addr = '0;
                exp_wr   = 1'b0;
                exp_byte = 8'h00;
            end
            chk("ram_addr", ram_addr_out, exp_addr);
            chk("ram_wr", 32'(ram_wr_out), 32'(exp_wr));
            chk("ram_data", 32'(ram_data_out), 32'(exp_byte));
            if (c < done_cyc) begin
                chk("busy", 32'(busy_out), 32'(exp_busy));
                chk("early if_done", 32'(if_done_out), 32'd0);
                chk("early mem_done", 32'(mem_done_out), 32'd0);
            end else begin
                chk("done busy", 32'(busy_out), 32'd0);
                chk("if_done", 32'(if_done_out), 32'(kind == K_IF));
                chk("mem_done", 32'(mem_done_out), 32'(kind != K_IF));
                chk("if_inst", if_inst_out, (kind == K_IF) ? exp_rd : 32'd0);
                chk("mem_val", mem_val_read_out, (kind == K_RD) ? exp_rd : 32'd0);
            end
        end
        if_req_in = 1'b0;
        if (kind == K_WR)
            for (int k = 0; k < n; k++) model_mem[16'(addr + 32'(k))] = 8'(val >> (8 * k));
        @(negedge clk_in);
        chk_quiet("after done");
        chk("after done mem_val", mem_val_read_out, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst_in           = 1'b0;
        if_req_in        = 1'b0;
        if_addr_in       = '0;
        mem_read_req_in  = 1'b0;
        mem_write_req_in = 1'b0;
        mem_addr_in      = '0;
        mem_val_in       = '0;
        mem_len_in       = '0;
        for (int i = 0; i < 65536; i++) model_mem[i] = pat(i);
        model_mem[16'h0007] = 8'h80;
        model_mem[16'h0010] = 8'h34;
        model_mem[16'h0011] = 8'h12;
        model_mem[16'h1000] = 8'h13;
        model_mem[16'h1001] = 8'h05;
        model_mem[16'h1002] = 8'h00;
        model_mem[16'h1003] = 8'h00;

        vecs[0]  = '{K_WR, 32'h0000_0020, 3'b011, 32'hDEAD_BEEF, 4, 32'h0};
        vecs[1]  = '{K_RD, 32'h0000_0020, 3'b100, 32'h0,         4, 32'hDEAD_BEEF};
        vecs[2]  = '{K_RD, 32'h0000_0020, 3'b001, 32'h0,         1, 32'h0000_00EF};
        vecs[3]  = '{K_RD, 32'h0000_0022, 3'b010, 32'h0,         2, 32'h0000_DEAD};
        vecs[4]  = '{K_WR, 32'h0000_0040, 3'b000, 32'h1234_5678, 1, 32'h0};
        vecs[5]  = '{K_WR, 32'h0000_0041, 3'b001, 32'hCAFE_9ABC, 2, 32'h0};
        vecs[6]  = '{K_RD, 32'h0000_0040, 3'b111, 32'h0,         4, 32'h439A_BC78};
        vecs[7]  = '{K_WR, 32'h0000_0050, 3'b101, 32'h0102_0304, 4, 32'h0};
        vecs[8]  = '{K_RD, 32'h0000_0050, 3'b000, 32'h0,         4, 32'h0102_0304};
        vecs[9]  = '{K_RD, 32'h0000_0060, 3'b010, 32'h0,         2, 32'h0000_6160};
        vecs[10] = '{K_IF, 32'h0000_0020, 3'b000, 32'h0,         4, 32'hDEAD_BEEF};
        vecs[11] = '{K_WR, 32'hFFFF_FFFE, 3'b011, 32'h1122_3344, 4, 32'h0};
        vecs[12] = '{K_RD, 32'hFFFF_FFFF, 3'b010, 32'h0,         2, 32'h0000_2233};
        vecs[13] = '{K_RD, 32'h0000_0007, 3'b001, 32'h0,         1, 32'h0000_0080};
        vecs[14] = '{K_RD, 32'h0000_0010, 3'b010, 32'h0,         2, 32'h0000_1234};
        vecs[15] = '{K_IF, 32'h0000_1000, 3'b000, 32'h0,         4, 32'h0000_0513};

        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b1;

        foreach (vecs[i])
            run_access(vecs[i].kind, vecs[i].addr, vecs[i].len, vecs[i].val, vecs[i].n, vecs[i].exp_rd);

        // Fetch aborted by a MEM load raised in its second cycle.
        if_req_in  = 1'b1;
        if_addr_in = 32'h0000_1000;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("abort busy if", 32'(busy_out), 32'h1);
        chk("abort addr0", ram_addr_out, 32'h0000_1000);
        @(negedge clk_in);
        chk("abort addr1", ram_addr_out, 32'h0000_1001);
        mem_read_req_in = 1'b1;
        mem_addr_in     = 32'h0000_0020;
        mem_len_in      = 3'b100;
        @(posedge clk_in);
        @(negedge clk_in);
        mem_read_req_in = 1'b0;
        if_req_in       = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk_in);
            chk("abort no if_done", 32'(if_done_out), 32'd0);
            if (c == 1) chk("abort rd addr0", ram_addr_out, 32'h0000_0020);
            if (c < 6) begin
                chk("abort busy rd", 32'(busy_out), 32'h2);
                chk("abort early mem_done", 32'(mem_done_out), 32'd0);
            end else begin
                chk("abort mem_done", 32'(mem_done_out), 32'd1);
                chk("abort mem_val", mem_val_read_out, model_word(32'h20, 4));
            end
        end
        @(negedge clk_in);
        chk_quiet("abort idle");
        run_access(K_IF, 32'h0000_1000, 3'b000, 32'h0, 4, model_word(32'h1000, 4));

        // Fetch abandoned by its requester.
        if_req_in  = 1'b1;
        if_addr_in = 32'h0000_1000;
        @(posedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);
        if_req_in = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk_in);
            chk_quiet("if drop");
        end

        // Simultaneous IF and MEM requests: MEM first, then the held IF.
        if_req_in       = 1'b1;
        if_addr_in      = 32'h0000_1000;
        mem_read_req_in = 1'b1;
        mem_addr_in     = 32'h0000_0010;
        mem_len_in      = 3'b010;
        @(posedge clk_in);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            mem_read_req_in = 1'b0;
            chk("prio if_done", 32'(if_done_out), 32'(c == 11));
            chk("prio mem_done", 32'(mem_done_out), 32'(c == 4));
            if (c == 1) chk("prio busy rd", 32'(busy_out), 32'h2);
            if (c == 4) chk("prio mem_val", mem_val_read_out, model_word(32'h10, 2));
            if (c == 5) chk("prio gap busy", 32'(busy_out), 32'h0);
            if (c == 6) chk("prio busy if", 32'(busy_out), 32'h1);
            if (c == 11) begin
                chk("prio if_inst", if_inst_out, model_word(32'h1000, 4));
                if_req_in = 1'b0;
            end
        end

        // Reset asserted while byte 2 of a store is on the bus.
        mem_write_req_in = 1'b1;
        mem_addr_in      = 32'h0000_0300;
        mem_len_in       = 3'b011;
        mem_val_in       = 32'hAABB_CCDD;
        @(posedge clk_in);
        @(negedge clk_in);
        mem_write_req_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst mid addr", ram_addr_out, 32'h0000_0302);
        chk("rst mid wr", 32'(ram_wr_out), 32'd1);
        #1 rst_in = 1'b0;
        #1 chk_all_zero("rst mid");
        repeat (3) begin
            @(negedge clk_in);
            chk_all_zero("rst hold");
        end
        rst_in = 1'b1;
        model_mem[16'h0300] = 8'hDD;
        model_mem[16'h0301] = 8'hCC;
        run_access(K_RD, 32'h0000_0300, 3'b100, 32'h0, 4, model_word(32'h300, 4));
        run_access(K_WR, 32'h0000_0300, 3'b011, 32'h5566_7788, 4, 32'h0);
        run_access(K_RD, 32'h0000_0300, 3'b100, 32'h0, 4, model_word(32'h300, 4));

        // Random traffic against the byte-array model.
        for (int i = 0; i < 40; i++) begin
            int          kind;
            int          n;
            logic [31:0] addr;
            logic [2:0]  len;
            logic [31:0] val;
            kind = int'($urandom_range(0, 2));
            addr = 32'($urandom_range(32'h2000, 32'hEFFF));
            len  = 3'($urandom_range(0, 7));
            val  = $urandom;
            n    = model_len(kind, len);
            w    = (kind == K_WR) ? 32'h0 : model_word(addr, n);
            run_access(kind, addr, len, val, n, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
